score_accumulator: RTL and testbench

//  Converts per-note judgement events into the running statistics shown on the scoreboard display.

---
 rtl/score_accumulator_pkg.sv | 55 +++++
 rtl/score_accumulator_if.sv | 27 ++
 rtl/score_accumulator_seq_divider.sv | 65 ++++++
 rtl/score_accumulator.sv | 176 +++++++++++++++++
 tb/tb_score_accumulator.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/score_accumulator_pkg.sv
// rtl/score_accumulator_pkg.sv - shared judgement codes, point tables and grade thresholds
// Shared by every score_accumulator file.
package score_accumulator_pkg;

    typedef enum logic [1:0] {
        JUDGE_MISS    = 2'd0,
        JUDGE_GOOD    = 2'd1,
        JUDGE_GREAT   = 2'd2,
        JUDGE_PERFECT = 2'd3
    } judge_e;

    typedef enum logic [1:0] {
        ACC_IDLE = 2'd0,
        ACC_LOAD = 2'd1,
        ACC_DIV  = 2'd2,
        ACC_DONE = 2'd3
    } acc_state_e;

    localparam int ACC_SCALE = 10000;
    localparam int DIV_W     = 32;

    localparam logic [31:0] GRADE5_MIN = 32'd9500;
    localparam logic [31:0] GRADE4_MIN = 32'd9000;
    localparam logic [31:0] GRADE3_MIN = 32'd8000;
    localparam logic [31:0] GRADE2_MIN = 32'd7000;
    localparam logic [31:0] GRADE1_MIN = 32'd6000;

    function automatic logic [8:0] base_points(judge_e kind);
        case (kind)
            JUDGE_GOOD:    return 9'd100;
            JUDGE_GREAT:   return 9'd200;
            JUDGE_PERFECT: return 9'd300;
            default:       return 9'd0;
        endcase
    endfunction

    function automatic logic [1:0] weight_points(judge_e kind);
        case (kind)
            JUDGE_GOOD:    return 2'd1;
            JUDGE_GREAT:   return 2'd2;
            JUDGE_PERFECT: return 2'd3;
            default:       return 2'd0;
        endcase
    endfunction

    function automatic logic [2:0] grade_of(logic [31:0] acc);
        if (acc >= GRADE5_MIN)      return 3'd5;
        else if (acc >= GRADE4_MIN) return 3'd4;
        else if (acc >= GRADE3_MIN) return 3'd3;
        else if (acc >= GRADE2_MIN) return 3'd2;
        else if (acc >= GRADE1_MIN) return 3'd1;
        else                        return 3'd0;
    endfunction

endpackage

// File: rtl/score_accumulator_if.sv
// rtl/score_accumulator_if.sv - judgement event inputs and scoreboard statistic outputs
// The slave side is the accumulator; the master side is whoever produces judgements.
interface score_accumulator_if #(
    parameter int SCORE_W = 21
);
    logic               en;
    logic               clear;
    logic               judge_valid;
    logic [1:0]         judge_kind;
    logic [SCORE_W-1:0] combo;
    logic [SCORE_W-1:0] base_score;
    logic [SCORE_W-1:0] bonus_score;
    logic [SCORE_W-1:0] acc;
    logic               acc_valid;
    logic [2:0]         level;
    logic [SCORE_W-1:0] max_combo;

    modport master (
        output en, clear, judge_valid, judge_kind,
        input  combo, base_score, bonus_score, acc, acc_valid, level, max_combo
    );

    modport slave (
        input  en, clear, judge_valid, judge_kind,
        output combo, base_score, bonus_score, acc, acc_valid, level, max_combo
    );
endinterface

// File: rtl/score_accumulator_seq_divider.sv
// rtl/score_accumulator_seq_divider.sv - restoring divider, one quotient bit per enabled cycle
// o_done is high during the final iteration; o_quotient is complete on the following cycle.
module seq_divider #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic         i_start,
    input  logic [W-1:0] i_dividend,
    input  logic [W-1:0] i_divisor,
    output logic         o_busy,
    output logic         o_done,
    output logic [W-1:0] o_quotient
);
    localparam int CNT_W = $clog2(W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    logic [W-1:0]     r_rem;
    logic [W-1:0]     r_quo;
    logic [W-1:0]     r_dvs;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;

    logic [W:0] w_shift;
    logic [W:0] w_diff;
    logic       w_last;

    // The dividend is shifted out of r_quo while quotient bits shift in behind it.
    assign w_shift = {r_rem, r_quo[W-1]};
    assign w_diff  = w_shift - {1'b0, r_dvs};
    assign w_last  = r_busy && (r_cnt == CNT_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_dvs  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_en) begin
            if (i_start) begin
                r_rem  <= '0;
                r_quo  <= i_dividend;
                r_dvs  <= i_divisor;
                r_cnt  <= '0;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                if (!w_diff[W]) begin
                    r_rem <= w_diff[W-1:0];
                    r_quo <= {r_quo[W-2:0], 1'b1};
                end else begin
                    r_rem <= w_shift[W-1:0];
                    r_quo <= {r_quo[W-2:0], 1'b0};
                end
                r_cnt <= r_cnt + 1'b1;
                if (w_last) r_busy <= 1'b0;
            end
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = w_last;
    assign o_quotient = r_quo;
endmodule

// File: rtl/score_accumulator.sv
// rtl/score_accumulator.sv - per-note judgements to combo/score/accuracy/grade statistics
// Optional SCORE_MAXCOMBO_EN adds the longest-combo register; otherwise max_combo is 0.
module score_accumulator
    import score_accumulator_pkg::*;
#(
    parameter int NOTE_W   = 16,
    parameter int SCORE_W  = 21,
    parameter int BONUS_SH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    score_accumulator_if.slave   bus
);
    localparam int PTS_W = NOTE_W + 2;
    localparam logic [NOTE_W-1:0]  NOTE_MAX  = '1;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    logic [NOTE_W-1:0]  r_notes;
    logic [PTS_W-1:0]   r_points;
    logic [SCORE_W-1:0] r_combo;
    logic [SCORE_W-1:0] r_base;
    logic [SCORE_W-1:0] r_bonus;
    logic [SCORE_W-1:0] r_acc;
    logic [2:0]         r_level;
    logic               r_acc_valid;
    logic               r_dirty;
    acc_state_e         r_state;

    acc_state_e         w_state_next;
    logic               w_load;
    logic               w_div_start;
    logic               w_publish;
    logic               w_div_busy;
    logic               w_div_done;
    logic [DIV_W-1:0]   w_quotient;
    logic [DIV_W-1:0]   w_num;
    logic [DIV_W-1:0]   w_den;
    logic               w_clr;

    judge_e             w_kind;
    logic               w_accept;
    logic               w_hit;
    logic [SCORE_W:0]   w_combo_sum;
    logic [SCORE_W-1:0] w_combo_next;
    logic [SCORE_W-1:0] w_bonus_add;
    logic [SCORE_W:0]   w_bonus_sum;
    logic [SCORE_W:0]   w_base_sum;

    assign w_clr    = rst | bus.clear;
    assign w_kind   = judge_e'(bus.judge_kind);
    assign w_accept = bus.en & bus.judge_valid & ~bus.clear & (r_notes != NOTE_MAX);
    assign w_hit    = (w_kind != JUDGE_MISS);

    // Every accumulator clamps at all-ones rather than wrapping.
    assign w_combo_sum  = {1'b0, r_combo} + 1'b1;
    assign w_combo_next = !w_hit ? '0
                        : (w_combo_sum[SCORE_W] ? SCORE_MAX : w_combo_sum[SCORE_W-1:0]);
    assign w_bonus_add  = w_hit ? (w_combo_next >> BONUS_SH) : '0;
    assign w_bonus_sum  = {1'b0, r_bonus} + {1'b0, w_bonus_add};
    assign w_base_sum   = {1'b0, r_base} + {{(SCORE_W-8){1'b0}}, base_points(w_kind)};

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_notes  <= '0;
            r_points <= '0;
            r_combo  <= '0;
            r_base   <= '0;
            r_bonus  <= '0;
        end else if (w_accept) begin
            r_notes  <= r_notes + 1'b1;
            r_points <= r_points + {{(PTS_W-2){1'b0}}, weight_points(w_kind)};
            r_combo  <= w_combo_next;
            r_base   <= w_base_sum[SCORE_W]  ? SCORE_MAX : w_base_sum[SCORE_W-1:0];
            r_bonus  <= w_bonus_sum[SCORE_W] ? SCORE_MAX : w_bonus_sum[SCORE_W-1:0];
        end
    end

`ifdef SCORE_MAXCOMBO_EN
    logic [SCORE_W-1:0] r_max_combo;

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_max_combo <= '0;
        end else if (w_accept && (w_combo_next > r_max_combo)) begin
            r_max_combo <= w_combo_next;
        end
    end

    assign bus.max_combo = r_max_combo;
`else
    assign bus.max_combo = '0;
`endif

    assign w_num = {{(DIV_W-PTS_W){1'b0}}, r_points} * DIV_W'(ACC_SCALE);
    assign w_den = {{(DIV_W-NOTE_W){1'b0}}, r_notes} * DIV_W'(3);

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_state <= ACC_IDLE;
        end else if (bus.en) begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_div_start  = 1'b0;
        w_publish    = 1'b0;
        case (r_state)
            ACC_IDLE: if (r_dirty) w_state_next = ACC_LOAD;
            ACC_LOAD: begin
                w_load = 1'b1;
                if (w_den == '0) begin
                    w_state_next = ACC_IDLE;
                end else begin
                    w_div_start  = 1'b1;
                    w_state_next = ACC_DIV;
                end
            end
            ACC_DIV:  if (w_div_done || !w_div_busy) w_state_next = ACC_DONE;
            ACC_DONE: begin
                w_publish    = 1'b1;
                w_state_next = ACC_IDLE;
            end
            default:  w_state_next = ACC_IDLE;
        endcase
    end

    // A same-cycle accepted event outranks LOAD/DONE so its dirty mark is never lost.
    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_acc       <= '0;
            r_level     <= '0;
            r_acc_valid <= 1'b1;
            r_dirty     <= 1'b0;
        end else if (bus.en) begin
            if (w_load) r_dirty <= 1'b0;
            if (w_load && (w_den == '0)) begin
                r_acc       <= '0;
                r_level     <= '0;
                r_acc_valid <= 1'b1;
            end
            if (w_publish) begin
                r_acc       <= w_quotient[SCORE_W-1:0];
                r_level     <= grade_of(w_quotient);
                r_acc_valid <= ~r_dirty;
            end
            if (w_accept) begin
                r_dirty     <= 1'b1;
                r_acc_valid <= 1'b0;
            end
        end
    end

    seq_divider #(
        .W (DIV_W)
    ) u_div (
        .i_clk      (clk),
        .i_rst      (w_clr),
        .i_en       (bus.en),
        .i_start    (w_div_start),
        .i_dividend (w_num),
        .i_divisor  (w_den),
        .o_busy     (w_div_busy),
        .o_done     (w_div_done),
        .o_quotient (w_quotient)
    );

    assign bus.combo       = r_combo;
    assign bus.base_score  = r_base;
    assign bus.bonus_score = r_bonus;
    assign bus.acc         = r_acc;
    assign bus.acc_valid   = r_acc_valid;
    assign bus.level       = r_level;
endmodule

// File: tb/tb_score_accumulator.sv
// tb/tb_score_accumulator.sv - directed self-checking bench for score_accumulator
// Expected values come from hand-computed constants and a small reference model.
module tb_score_accumulator;
    localparam int SMAX = 2097151;

    logic clk = 1'b0;
    logic rst = 1'b1;

    score_accumulator_if bus ();

    score_accumulator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    int m_combo, m_base, m_bonus, m_points, m_notes, m_maxc;
    int base_tab[4] = '{0, 100, 200, 300};

    task automatic check(input string tag, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, want);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_combo = 0; m_base = 0; m_bonus = 0;
        m_points = 0; m_notes = 0; m_maxc = 0;
    endtask

    task automatic send(input int k);
        bus.judge_valid = 1'b1;
        bus.judge_kind  = 2'(k);
        tick();
        bus.judge_valid = 1'b0;
        m_notes++;
        m_points += k;
        m_base = (m_base + base_tab[k] > SMAX) ? SMAX : m_base + base_tab[k];
        if (k == 0) begin
            m_combo = 0;
        end else begin
            m_combo = (m_combo + 1 > SMAX) ? SMAX : m_combo + 1;
            m_bonus = (m_bonus + (m_combo >> 4) > SMAX) ? SMAX : m_bonus + (m_combo >> 4);
            if (m_combo > m_maxc) m_maxc = m_combo;
        end
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        model_reset();
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!bus.acc_valid && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, int'(bus.acc_valid), 1);
    endtask

    function automatic int model_acc();
        return (m_notes == 0) ? 0 : (m_points * 10000) / (m_notes * 3);
    endfunction

    function automatic int model_level(input int a);
        if (a >= 9500) return 5;
        if (a >= 9000) return 4;
        if (a >= 8000) return 3;
        if (a >= 7000) return 2;
        if (a >= 6000) return 1;
        return 0;
    endfunction

    task automatic check_model(input string tag);
        check({tag, "_combo"}, int'(bus.combo), m_combo);
        check({tag, "_base"},  int'(bus.base_score), m_base);
        check({tag, "_bonus"}, int'(bus.bonus_score), m_bonus);
    endtask

    initial begin
        int lat;
        int high_cnt;
        int want_max;

        bus.en = 1'b1;
        bus.clear = 1'b0;
        bus.judge_valid = 1'b0;
        bus.judge_kind = 2'd0;
        model_reset();
        repeat (3) tick();
        rst = 1'b0;
        tick();

        check("rst_combo", int'(bus.combo), 0);
        check("rst_base", int'(bus.base_score), 0);
        check("rst_bonus", int'(bus.bonus_score), 0);
        check("rst_acc", int'(bus.acc), 0);
        check("rst_acc_valid", int'(bus.acc_valid), 1);
        check("rst_level", int'(bus.level), 0);
        check("rst_max_combo", int'(bus.max_combo), 0);

        repeat (4) send(3);
        check("p4_combo", int'(bus.combo), 4);
        check("p4_base", int'(bus.base_score), 1200);
        check("p4_bonus", int'(bus.bonus_score), 0);
        check("p4_valid_low", int'(bus.acc_valid), 0);
        wait_valid("p4");
        check("p4_acc", int'(bus.acc), 10000);
        check("p4_level", int'(bus.level), 5);

        do_clear();
        repeat (16) send(3);
        check("p16_combo", int'(bus.combo), 16);
        send(0);
        check("miss_combo", int'(bus.combo), 0);
        check("miss_bonus", int'(bus.bonus_score), 1);
        check("miss_base", int'(bus.base_score), 4800);
        wait_valid("miss");
        check("miss_acc", int'(bus.acc), 9411);
        check("miss_level", int'(bus.level), 4);
`ifdef SCORE_MAXCOMBO_EN
        want_max = 16;
`else
        want_max = 0;
`endif
        check("miss_max_combo", int'(bus.max_combo), want_max);

        do_clear();
        send(1); send(2); send(0); send(3);
        check("mix_base", int'(bus.base_score), 600);
        check("mix_combo", int'(bus.combo), 1);
        wait_valid("mix");
        check("mix_acc", int'(bus.acc), 5000);
        check("mix_level", int'(bus.level), 0);

        send(3);
        lat = 1;
        while (!bus.acc_valid && lat < 100) begin
            tick();
            lat++;
        end
        check("single_latency", lat, 36);
        check("single_acc", int'(bus.acc), 6000);
        check("single_level", int'(bus.level), 1);

        do_clear();
        high_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            send((i * 3 + 1) % 4);
            if (bus.acc_valid) high_cnt++;
        end
        check("burst_valid_low", high_cnt, 0);
        check_model("burst");
        wait_valid("burst");
        check("burst_acc", int'(bus.acc), model_acc());
        check("burst_level", int'(bus.level), model_level(model_acc()));

        send(1);
        repeat (10) tick();
        bus.clear = 1'b1;
        bus.judge_valid = 1'b1;
        bus.judge_kind = 2'd3;
        tick();
        bus.clear = 1'b0;
        bus.judge_valid = 1'b0;
        model_reset();
        check_model("clr");
        check("clr_acc", int'(bus.acc), 0);
        check("clr_acc_valid", int'(bus.acc_valid), 1);
        check("clr_level", int'(bus.level), 0);
        repeat (40) tick();
        check("clr_drop_valid", int'(bus.acc_valid), 1);
        check("clr_drop_base", int'(bus.base_score), 0);

        send(2);
        wait_valid("en");
        check("en_acc", int'(bus.acc), 6666);
        bus.en = 1'b0;
        bus.judge_valid = 1'b1;
        bus.judge_kind = 2'd3;
        tick();
        bus.judge_valid = 1'b0;
        check("en_off_combo", int'(bus.combo), 1);
        check("en_off_base", int'(bus.base_score), 200);
        bus.en = 1'b1;
        send(3);
        repeat (10) tick();
        bus.en = 1'b0;
        repeat (50) tick();
        check("freeze_valid", int'(bus.acc_valid), 0);
        check("freeze_acc", int'(bus.acc), 6666);
        bus.en = 1'b1;
        wait_valid("resume");
        check("resume_acc", int'(bus.acc), 8333);
        check("resume_level", int'(bus.level), 3);

        do_clear();
        repeat (6991) send(3);
        check("sat_base", int'(bus.base_score), SMAX);
        check_model("sat");
        wait_valid("sat");
        check("sat_acc", int'(bus.acc), 10000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
